// File: rtl/fetch_pkg.sv
// Shared types and default sizing for the instruction fetch stage.
// A buffer entry pairs an instruction word with the PC it was fetched from.
package fetch_pkg;

    localparam int FETCH_ADDR_WIDTH  = 5;
    localparam int FETCH_INSTR_WIDTH = 16;
    localparam int FETCH_FIFO_DEPTH  = 4;

    typedef struct packed {
        logic [FETCH_ADDR_WIDTH-1:0]  pc;
        logic [FETCH_INSTR_WIDTH-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular buffer of fetch entries that accepts up to two writes and one read per cycle.
// A flush empties it and takes priority over any push or pop in the same cycle.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = FETCH_FIFO_DEPTH,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     push_count,
    input  fetch_entry_t   entry_0,
    input  fetch_entry_t   entry_1,
    input  logic           flush,
    input  logic           pop,
    output logic [CW-1:0]  count,
    output fetch_entry_t   head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  wr_ptr_nxt;
    logic [PW-1:0]  rd_ptr;
    logic [CW-1:0]  count_q;
    logic [CW-1:0]  free;

    assign wr_ptr_nxt = wr_ptr + PW'(1);
    assign free       = CW'(DEPTH) - count_q;
    assign count      = count_q;
    assign head       = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            wr_ptr  <= wr_ptr + PW'(push_count);
            rd_ptr  <= rd_ptr + PW'(pop);
            count_q <= count_q + CW'(push_count) - CW'(pop);
        end
    end

    // Storage needs no reset: entries are only observed once count covers them.
    always_ff @(posedge clk) begin
        if (!flush) begin
            if (push_count != 2'd0) mem[wr_ptr]     <= entry_0;
            if (push_count == 2'd2) mem[wr_ptr_nxt] <= entry_1;
        end
    end

    a_push_fits: assert property (@(posedge clk) disable iff (!rst_n)
        (flush || (CW'(push_count) <= free)));

endmodule

// File: rtl/instr_fetch_unit.sv
// Dual-issue fetch stage: owns the PC, reads PC and PC+1 from the instruction ROM,
// buffers them with their PCs and hands one per cycle to decode; redirects flush the buffer.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH_IM = FETCH_ADDR_WIDTH,
    parameter int INSTR_WIDTH   = FETCH_INSTR_WIDTH,
    parameter int FIFO_DEPTH    = FETCH_FIFO_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     fetch_enable,
    input  logic                     redirect_valid,
    input  logic [ADDR_WIDTH_IM-1:0] redirect_pc,
    output logic [ADDR_WIDTH_IM-1:0] imem_addr_1,
    output logic [ADDR_WIDTH_IM-1:0] imem_addr_2,
    input  logic [INSTR_WIDTH-1:0]   imem_data_1,
    input  logic [INSTR_WIDTH-1:0]   imem_data_2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [INSTR_WIDTH-1:0]   out_instr,
    output logic [ADDR_WIDTH_IM-1:0] out_pc
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // The entry struct is sized by the package, so the widths must agree with it.
    if (ADDR_WIDTH_IM != FETCH_ADDR_WIDTH || INSTR_WIDTH != FETCH_INSTR_WIDTH) begin : g_width_check
        $error("instr_fetch_unit widths must match fetch_pkg");
    end

    logic [ADDR_WIDTH_IM-1:0] pc_q;
    logic [CW-1:0]            count;
    logic [CW-1:0]            free;
    logic [1:0]               push_count;
    logic                     pop;
    logic                     buf_nonempty;
    fetch_entry_t             entry_0;
    fetch_entry_t             entry_1;
    fetch_entry_t             head;

    assign imem_addr_1 = pc_q;
    assign imem_addr_2 = pc_q + ADDR_WIDTH_IM'(1);

    // Space is judged on the registered count; a pop in this cycle does not free a slot.
    assign free = CW'(FIFO_DEPTH) - count;

    always_comb begin
        push_count = 2'd0;
        if (fetch_enable && !redirect_valid) begin
            if (free >= CW'(2))      push_count = 2'd2;
            else if (free == CW'(1)) push_count = 2'd1;
        end
    end

    assign entry_0 = '{pc: imem_addr_1, instr: imem_data_1};
    assign entry_1 = '{pc: imem_addr_2, instr: imem_data_2};

    // Handshake: the head transfers on any rising edge where out_valid && out_ready.
    // out_valid never depends on out_ready, and a redirect suppresses it for that cycle.
    assign buf_nonempty = (count != '0);
    assign out_valid    = buf_nonempty && !redirect_valid;
    assign pop          = out_valid && out_ready;
    assign out_instr    = buf_nonempty ? head.instr : '0;
    assign out_pc       = buf_nonempty ? head.pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= '0;
        end else if (redirect_valid) begin
            pc_q <= redirect_pc;
        end else begin
            pc_q <= pc_q + ADDR_WIDTH_IM'(push_count);
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push_count (push_count),
        .entry_0    (entry_0),
        .entry_1    (entry_1),
        .flush      (redirect_valid),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

endmodule
